// File: rtl/boot_loader.sv
// Program loader and run monitor: streams bytes into instruction RAM, pads the last word,
// releases the CPU, then watches fetches for a halt or a watchdog timeout.
module boot_loader #(
    parameter int                 ADDR_W    = 8,
    parameter int                 BPW       = 4,
    parameter int                 BASE_ADDR = 0,
    parameter logic [8*BPW-1:0]   HALT_WORD = {(8*BPW){1'b1}},
    parameter int                 MAX_RUN   = 1024
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [7:0]          mem_wdata,
    output logic                echo_valid,
    output logic [8*BPW-1:0]    echo_word,
    output logic                cpu_hold,
    input  logic                fetch_valid,
    input  logic [ADDR_W-1:0]   fetch_addr,
    input  logic [8*BPW-1:0]    fetch_word,
    output logic [ADDR_W:0]     loaded_bytes,
    output logic                done,
    output logic [1:0]          err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PAD   = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    localparam int                LANE_W    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BPW - 1);
    localparam logic [ADDR_W:0]   CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       WD_LAST   = 32'(MAX_RUN - 1);
    localparam bit                WD_EN     = (MAX_RUN != 0);

    logic [2:0]         r_state;
    logic [ADDR_W-1:0]  r_ptr;
    logic [ADDR_W:0]    r_cnt;
    logic [LANE_W-1:0]  r_lane;
    logic [31:0]        r_wdog;
    logic               r_in_ready;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [7:0]         r_mem_wdata;
    logic               r_echo_valid;
    logic [8*BPW-1:0]   r_echo_word;
    logic               r_cpu_hold;
    logic               r_done;
    logic [1:0]         r_err;

    logic               w_accept;
    logic               w_overflow;
    logic               w_word_end;
    logic               w_pad_write;
    logic               w_write;
    logic [7:0]         w_wr_data;
    logic               w_load_entry;
    logic [ADDR_W-1:0]  w_rel;
    logic               w_halt;
    logic               w_wd_expire;

    // in_ready is only ever high in LOAD, so it doubles as the state qualifier
    assign w_accept     = r_in_ready && in_valid;
    assign w_overflow   = (r_cnt == CAPACITY);
    assign w_word_end   = (r_lane == LANE_LAST);
    assign w_pad_write  = (r_state == S_PAD) && (r_lane != {LANE_W{1'b0}});
    assign w_write      = (w_accept && !w_overflow) || w_pad_write;
    assign w_wr_data    = (r_state == S_PAD) ? 8'h00 : in_data;
    assign w_load_entry = start && ((r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_ERROR));
    assign w_rel        = fetch_addr - BASE;
    assign w_halt       = fetch_valid && ((fetch_word == HALT_WORD) || ({1'b0, w_rel} >= r_cnt));
    assign w_wd_expire  = WD_EN && (r_wdog == WD_LAST);

    // Control: state sequencing, handshake, CPU hold, status and watchdog
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 2'b00;
            r_wdog     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_in_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 2'b00;
                    end
                end
                S_LOAD: begin
                    if (w_accept && w_overflow) begin
                        r_state    <= S_ERROR;
                        r_in_ready <= 1'b0;
                        r_err      <= 2'b01;
                    end else if (w_accept && in_last) begin
                        r_state    <= S_PAD;
                        r_in_ready <= 1'b0;
                    end
                end
                S_PAD: begin
                    // An already word-aligned count still spends one cycle here so the
                    // CPU is released one cycle after the final write.
                    if (!w_pad_write) begin
                        r_state    <= S_RUN;
                        r_cpu_hold <= 1'b0;
                        r_wdog     <= 32'd0;
                    end
                end
                S_RUN: begin
                    if (w_halt) begin
                        r_state    <= S_HALT;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b1;
                    end else if (w_wd_expire) begin
                        r_state    <= S_ERROR;
                        r_cpu_hold <= 1'b1;
                        r_err      <= 2'b10;
                    end else begin
                        r_wdog <= r_wdog + 32'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_cpu_hold <= 1'b1;
                end
            endcase
        end
    end

    // Datapath: registered RAM writes, word echo and byte accounting
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_ptr        <= {ADDR_W{1'b0}};
            r_cnt        <= {(ADDR_W+1){1'b0}};
            r_lane       <= {LANE_W{1'b0}};
            r_mem_we     <= 1'b0;
            r_mem_addr   <= {ADDR_W{1'b0}};
            r_mem_wdata  <= 8'h00;
            r_echo_valid <= 1'b0;
            r_echo_word  <= {(8*BPW){1'b0}};
        end else begin
            r_mem_we     <= 1'b0;
            r_echo_valid <= 1'b0;
            if (w_write) begin
                r_mem_we     <= 1'b1;
                r_mem_addr   <= r_ptr;
                r_mem_wdata  <= w_wr_data;
                r_echo_word  <= (r_echo_word << 4'd8) | (8*BPW)'(w_wr_data);
                r_echo_valid <= w_word_end;
                r_ptr        <= r_ptr + ADDR_W'(1);
                r_cnt        <= r_cnt + (ADDR_W+1)'(1);
                r_lane       <= w_word_end ? {LANE_W{1'b0}} : r_lane + LANE_W'(1);
            end else if (w_load_entry) begin
                r_ptr  <= BASE;
                r_cnt  <= {(ADDR_W+1){1'b0}};
                r_lane <= {LANE_W{1'b0}};
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign echo_valid   = r_echo_valid;
    assign echo_word    = r_echo_word;
    assign cpu_hold     = r_cpu_hold;
    assign loaded_bytes = r_cnt;
    assign done         = r_done;
    assign err          = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a write scoreboard built from the byte list, a halt rule
// model, and literal expectations for echo words, counts and reset values.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        clr, start, in_valid, in_last, fetch_valid;
    logic [7:0]  in_data;
    logic [3:0]  fetch_addr;
    logic [31:0] fetch_word;
    logic        in_ready, mem_we, echo_valid, cpu_hold, done;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [31:0] echo_word;
    logic [4:0]  loaded_bytes;
    logic [1:0]  err;

    boot_loader #(
        .ADDR_W(4), .BPW(4), .BASE_ADDR(0), .HALT_WORD(32'hFFFF_FFFF), .MAX_RUN(20)
    ) dut (
        .clk(clk), .clr(clr), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .echo_valid(echo_valid), .echo_word(echo_word), .cpu_hold(cpu_hold),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_word(fetch_word),
        .loaded_bytes(loaded_bytes), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [7:0]  data;
        logic        ev;
        logic [31:0] ew;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] echo_log[$];
    int          vecs = 0;
    int          errs = 0;
    logic [7:0]  q_a[$], q_b[$], q_c[$], q_d[$], q_d16[$], q_e[$], q_f[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every write the DUT issues must be the next one the model predicts
    always @(negedge clk) begin
        wr_t w;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", mem_addr, mem_wdata);
            end else begin
                w = exp_q.pop_front();
                chk("wr_addr", {28'h0, mem_addr}, {28'h0, w.addr});
                chk("wr_data", {24'h0, mem_wdata}, {24'h0, w.data});
                chk("wr_echo_valid", {31'h0, echo_valid}, {31'h0, w.ev});
                if (w.ev) chk("wr_echo_word", echo_word, w.ew);
            end
            if (echo_valid === 1'b1) echo_log.push_back(echo_word);
        end else if (echo_valid === 1'b1) begin
            vecs++;
            errs++;
            $display("FAIL echo_without_write: echo_valid=1 mem_we=%b", mem_we);
        end
    end

    // Image layout: consecutive addresses from base 0 mod 16, zero pad, big-endian words
    task automatic expect_writes(input logic [7:0] b[$], input int n_pad);
        logic [7:0] all[$];
        all = b;
        repeat (n_pad) all.push_back(8'h00);
        for (int i = 0; i < all.size(); i++) begin
            wr_t w;
            w.addr = 4'(i % 16);
            w.data = all[i];
            w.ev   = ((i % 4) == 3);
            w.ew   = 32'h0;
            if (w.ev) w.ew = {all[i-3], all[i-2], all[i-1], all[i]};
            exp_q.push_back(w);
        end
    endtask

    function automatic bit halt_expected(input logic [3:0] a, input logic [31:0] w, input int loaded);
        return (w == 32'hFFFF_FFFF) || ((((int'(a) - 0) % 16 + 16) % 16) >= loaded);
    endfunction

    task automatic check_reset(input string p);
        chk({p, "in_ready"}, {31'h0, in_ready}, 32'd0);
        chk({p, "mem_we"}, {31'h0, mem_we}, 32'd0);
        chk({p, "mem_addr"}, {28'h0, mem_addr}, 32'd0);
        chk({p, "mem_wdata"}, {24'h0, mem_wdata}, 32'd0);
        chk({p, "echo_valid"}, {31'h0, echo_valid}, 32'd0);
        chk({p, "echo_word"}, echo_word, 32'd0);
        chk({p, "cpu_hold"}, {31'h0, cpu_hold}, 32'd1);
        chk({p, "loaded_bytes"}, {27'h0, loaded_bytes}, 32'd0);
        chk({p, "done"}, {31'h0, done}, 32'd0);
        chk({p, "err"}, {30'h0, err}, 32'd0);
    endtask

    task automatic do_start();
        echo_log.delete();
        @(posedge clk); #1;
        chk("ready_before_start", {31'h0, in_ready}, 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ready_rise", {31'h0, in_ready}, 32'd1);
        chk("load_err_clear", {30'h0, err}, 32'd0);
        chk("load_done_clear", {31'h0, done}, 32'd0);
        chk("load_hold", {31'h0, cpu_hold}, 32'd1);
        chk("load_count_clear", {27'h0, loaded_bytes}, 32'd0);
    endtask

    task automatic stream(input logic [7:0] b[$], input bit last, input int start_at);
        for (int i = 0; i < b.size(); i++) begin
            int t;
            in_valid = 1'b1;
            in_data  = b[i];
            in_last  = last && (i == b.size() - 1);
            start    = (i == start_at);
            t = 0;
            while (in_ready !== 1'b1 && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            if (t == 20) chk("ready_timeout", {31'h0, in_ready}, 32'd1);
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic full_load(input logic [7:0] b[$], input int start_at);
        int n, pad;
        n   = b.size();
        pad = (4 - n % 4) % 4;
        expect_writes(b, pad);
        stream(b, 1'b1, start_at);
        chk("ready_drop", {31'h0, in_ready}, 32'd0);
        repeat (pad) begin @(posedge clk); #1; end
        chk("hold_before_run", {31'h0, cpu_hold}, 32'd1);
        @(posedge clk); #1;
        chk("hold_fall", {31'h0, cpu_hold}, 32'd0);
        chk("writes_drained", exp_q.size(), 32'd0);
        chk("loaded_bytes", {27'h0, loaded_bytes}, 32'(n + pad));
    endtask

    task automatic fetch(input logic [3:0] a, input logic [31:0] w, input int loaded, input string nm);
        bit h;
        h = halt_expected(a, w, loaded);
        fetch_valid = 1'b1;
        fetch_addr  = a;
        fetch_word  = w;
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        chk({nm, "_done"}, {31'h0, done}, {31'h0, h});
        chk({nm, "_hold"}, {31'h0, cpu_hold}, {31'h0, h});
        chk({nm, "_err"}, {30'h0, err}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        clr = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        fetch_valid = 1'b0; fetch_addr = 4'h0; fetch_word = 32'h0;
        q_a = '{8'hE3, 8'hA0, 8'h10, 8'h04, 8'hE2, 8'h81, 8'h10, 8'h08};
        q_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        q_c = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        q_e = '{8'hA1, 8'hA2, 8'hA3};
        q_f = '{8'h5A};
        for (int i = 0; i < 17; i++) q_d.push_back(8'(i * 3 + 1));
        for (int i = 0; i < 16; i++) q_d16.push_back(q_d[i]);

        #12;
        check_reset("rst_");
        @(posedge clk); #1;
        clr = 1'b1;

        // Two full words, then run until a fetch leaves the image
        do_start();
        full_load(q_a, -1);
        chk("A_echo0", echo_log[0], 32'hE3A01004);
        chk("A_echo1", echo_log[1], 32'hE2811008);
        chk("A_loaded", {27'h0, loaded_bytes}, 32'd8);
        fetch(4'd0, 32'hE3A01004, 8, "A_f0");
        fetch(4'd4, 32'hE2811008, 8, "A_f4");
        fetch(4'd8, 32'h00000000, 8, "A_f8");
        chk("A_halt_done", {31'h0, done}, 32'd1);

        // Partial word with padding; a start mid-load must be ignored
        do_start();
        full_load(q_b, 2);
        chk("B_echo0", echo_log[0], 32'h11223344);
        chk("B_echo1", echo_log[1], 32'h55000000);
        chk("B_loaded", {27'h0, loaded_bytes}, 32'd8);
        fetch(4'd0, 32'h11223344, 8, "B_f0");
        fetch(4'd4, 32'hFFFFFFFF, 8, "B_f4");

        // Watchdog: no halting fetch for 20 RUN cycles
        do_start();
        full_load(q_c, -1);
        n = 0;
        while (cpu_hold === 1'b0 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("C_wd_cycles", n, 32'd20);
        chk("C_wd_err", {30'h0, err}, 32'd2);
        chk("C_wd_done", {31'h0, done}, 32'd0);
        do_start();

        // Overflow: 17th byte with the 16-byte RAM full is dropped
        expect_writes(q_d16, 0);
        stream(q_d, 1'b0, -1);
        chk("D_ready", {31'h0, in_ready}, 32'd0);
        chk("D_err", {30'h0, err}, 32'd1);
        chk("D_hold", {31'h0, cpu_hold}, 32'd1);
        chk("D_loaded", {27'h0, loaded_bytes}, 32'd16);
        chk("D_drained", exp_q.size(), 32'd0);
        @(posedge clk); #1;

        // clr mid-load, then a fresh single-byte load from the base address
        do_start();
        expect_writes(q_e, 0);
        stream(q_e, 1'b0, -1);
        @(negedge clk); #1;
        clr = 1'b0;
        #1;
        check_reset("clr_");
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        chk("E_idle_ready", {31'h0, in_ready}, 32'd0);
        do_start();
        full_load(q_f, -1);
        chk("E_echo0", echo_log[0], 32'h5A000000);
        chk("E_loaded", {27'h0, loaded_bytes}, 32'd4);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
